stream_rd_arbiter: RTL and testbench

Five-channel read arbiter between the stream-instruction dispatcher's click-based control channels and the single BRAM read port. Each channel posts a read request as a two-phase event. The block grants channels round-robin and issues one BRAM read per grant from an auto-incrementing stream pointer. It returns the 128-bit word with a two-phase completion event on the granted channel. It sits directly below the stream dispatcher and is the only master of the BRAM read interface.

---
 rtl/stream_rd_arbiter_if.sv | 40 ++++
 rtl/stream_rd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_stream_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_rd_arbiter_if.sv
// Signal bundle between the stream dispatcher click channels, stream_rd_arbiter and the BRAM read port.
// o_timeout_err is present only when RD_TIMEOUT_EN is defined.
interface stream_rd_arbiter_if #(
    parameter int unsigned NCH    = 5,
    parameter int unsigned DATA_W = 128
);
    logic [NCH-1:0]    i_drive;
    logic [NCH-1:0]    o_free;
    logic [NCH-1:0]    o_drive;
    logic [NCH-1:0]    i_free;
    logic [DATA_W-1:0] o_rd_data;
    logic [2:0]        o_rd_ch;
    logic              o_busy;
    logic              RD_START;
    logic [31:0]       RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_DONE;
`ifdef RD_TIMEOUT_EN
    logic              o_timeout_err;

    // master: the arbiter; slave: dispatcher channels plus BRAM
    modport master (
        input  i_drive, i_free, RD_DATA, RD_DONE,
        output o_free, o_drive, o_rd_data, o_rd_ch, o_busy, RD_START, RD_ADDR, o_timeout_err
    );
    modport slave (
        output i_drive, i_free, RD_DATA, RD_DONE,
        input  o_free, o_drive, o_rd_data, o_rd_ch, o_busy, RD_START, RD_ADDR, o_timeout_err
    );
`else
    modport master (
        input  i_drive, i_free, RD_DATA, RD_DONE,
        output o_free, o_drive, o_rd_data, o_rd_ch, o_busy, RD_START, RD_ADDR
    );
    modport slave (
        output i_drive, i_free, RD_DATA, RD_DONE,
        input  o_free, o_drive, o_rd_data, o_rd_ch, o_busy, RD_START, RD_ADDR
    );
`endif
endinterface

// File: rtl/stream_rd_arbiter.sv
// Round-robin arbiter from NCH two-phase click request channels onto the single BRAM read port.
// Optional RD_WAIT watchdog with sticky o_timeout_err when RD_TIMEOUT_EN is defined.
module stream_rd_arbiter #(
    parameter int unsigned NCH         = 5,
    parameter int unsigned DATA_W      = 128,
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int unsigned ADDR_STEP   = 16
`ifdef RD_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input logic                 clk,
    input logic                 rst,
    stream_rd_arbiter_if.master bus
);
    localparam int unsigned CH_W = 3;
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(NCH - 1);
    localparam logic [NCH-1:0]  CH_ONE   = NCH'(1);
    localparam logic [31:0]     STEP     = 32'(ADDR_STEP);
`ifdef RD_TIMEOUT_EN
    localparam int unsigned     WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [NCH-1:0]    drv_s1_q, drv_s1_d, drv_s2_q, drv_s2_d, drv_s3_q, drv_s3_d;
    logic [NCH-1:0]    fre_s1_q, fre_s1_d, fre_s2_q, fre_s2_d, fre_s3_q, fre_s3_d;
    logic [NCH-1:0]    pending_q, pending_d;
    logic [NCH-1:0]    free_q, free_d;
    logic [NCH-1:0]    drive_q, drive_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              rd_start_q, rd_start_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [31:0]       ptr_q, ptr_d;
    logic              arm_q, arm_d;
    logic              busy_q, busy_d;
`ifdef RD_TIMEOUT_EN
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    logic [NCH-1:0]    drv_edge;
    logic [NCH-1:0]    fre_edge;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    clr_mask;
    logic              win_found;
    logic [CH_W-1:0]   win_idx;

    // Two-flop synchronizers plus a third stage for toggle detection
    always_comb begin
        drv_s1_d = bus.i_drive;
        drv_s2_d = drv_s1_q;
        drv_s3_d = drv_s2_q;
        fre_s1_d = bus.i_free;
        fre_s2_d = fre_s1_q;
        fre_s3_d = fre_s2_q;
        drv_edge = drv_s2_q ^ drv_s3_q;
        fre_edge = fre_s2_q ^ fre_s3_q;
        ch_mask  = CH_ONE << rd_ch_q;
    end

    // Round-robin pick: first pending channel after last_grant
    always_comb begin
        logic [NCH-1:0] rot;
        int unsigned    idx;
        win_found = 1'b0;
        win_idx   = '0;
        rot       = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            rot = pending_q >> idx;
            if (!win_found && rot[0]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        free_d       = free_q;
        drive_d      = drive_q;
        rd_ch_d      = rd_ch_q;
        last_grant_d = last_grant_q;
        rd_start_d   = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        ptr_d        = ptr_q;
        arm_d        = arm_q;
        clr_mask     = '0;
`ifdef RD_TIMEOUT_EN
        wd_cnt_d     = '0;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    clr_mask     = CH_ONE << win_idx;
                    free_d       = free_q ^ clr_mask;
                    rd_ch_d      = win_idx;
                    last_grant_d = win_idx;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_start_d = 1'b1;
                rd_addr_d  = ptr_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.RD_DONE) begin
                    rd_data_d = bus.RD_DATA;
                    ptr_d     = ptr_q + STEP;
                    arm_d     = 1'b1;
                    state_d   = S_DELIVER;
                end
`ifdef RD_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    rd_data_d = '0;
                    timeout_d = 1'b1;
                    ptr_d     = ptr_q + STEP;
                    arm_d     = 1'b1;
                    state_d   = S_DELIVER;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            S_DELIVER: begin
                // Data word is already stable when the completion toggle goes out
                if (arm_q) begin
                    drive_d = drive_q ^ ch_mask;
                    arm_d   = 1'b0;
                end else if ((fre_edge & ch_mask) != '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new event in the clearing cycle is a fresh request and wins over the clear
        pending_d = (pending_q & ~clr_mask) | drv_edge;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            drv_s1_q     <= '0;
            drv_s2_q     <= '0;
            drv_s3_q     <= '0;
            fre_s1_q     <= '0;
            fre_s2_q     <= '0;
            fre_s3_q     <= '0;
            pending_q    <= '0;
            free_q       <= '0;
            drive_q      <= '0;
            rd_ch_q      <= '0;
            last_grant_q <= LAST_RST;
            rd_start_q   <= 1'b0;
            rd_addr_q    <= BASE_ADDR;
            rd_data_q    <= '0;
            ptr_q        <= BASE_ADDR;
            arm_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RD_TIMEOUT_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            drv_s1_q     <= drv_s1_d;
            drv_s2_q     <= drv_s2_d;
            drv_s3_q     <= drv_s3_d;
            fre_s1_q     <= fre_s1_d;
            fre_s2_q     <= fre_s2_d;
            fre_s3_q     <= fre_s3_d;
            pending_q    <= pending_d;
            free_q       <= free_d;
            drive_q      <= drive_d;
            rd_ch_q      <= rd_ch_d;
            last_grant_q <= last_grant_d;
            rd_start_q   <= rd_start_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            ptr_q        <= ptr_d;
            arm_q        <= arm_d;
            busy_q       <= busy_d;
`ifdef RD_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.o_free    = free_q;
    assign bus.o_drive   = drive_q;
    assign bus.o_rd_data = rd_data_q;
    assign bus.o_rd_ch   = rd_ch_q;
    assign bus.o_busy    = busy_q;
    assign bus.RD_START  = rd_start_q;
    assign bus.RD_ADDR   = rd_addr_q;
`ifdef RD_TIMEOUT_EN
    assign bus.o_timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_stream_rd_arbiter.sv
// Directed bench for stream_rd_arbiter: single read, pointer walk, contention, hold, reset, wrap.
// Timeout scenario is compiled in when RD_TIMEOUT_EN is defined.
module tb_stream_rd_arbiter;
    localparam int unsigned NCH = 5;
    localparam int unsigned DW  = 128;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [NCH-1:0] exp_free;
    logic [NCH-1:0] exp_drive;
    logic [31:0]    exp_addr;

    always #5 clk = ~clk;

    stream_rd_arbiter_if #(.NCH(NCH), .DATA_W(DW)) bus ();
    stream_rd_arbiter_if #(.NCH(NCH), .DATA_W(DW)) bus_w ();

    stream_rd_arbiter #(
        .NCH(NCH), .DATA_W(DW), .BASE_ADDR(32'hC000_0000), .ADDR_STEP(16)
`ifdef RD_TIMEOUT_EN
       ,.TIMEOUT_CYC(8)
`endif
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // Second instance starts just below the 32-bit wrap point
    stream_rd_arbiter #(
        .NCH(NCH), .DATA_W(DW), .BASE_ADDR(32'hFFFF_FFF0), .ADDR_STEP(16)
`ifdef RD_TIMEOUT_EN
       ,.TIMEOUT_CYC(8)
`endif
    ) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [2:0] ch);
        @(negedge clk);
        bus.i_drive[ch] = ~bus.i_drive[ch];
    endtask

    task automatic ack(input logic [2:0] ch);
        @(negedge clk);
        bus.i_free[ch] = ~bus.i_free[ch];
    endtask

    task automatic check_reset_vals();
        check_eq("rst_free",  128'(bus.o_free),    128'(0));
        check_eq("rst_drive", 128'(bus.o_drive),   128'(0));
        check_eq("rst_busy",  128'(bus.o_busy),    128'(0));
        check_eq("rst_start", 128'(bus.RD_START),  128'(0));
        check_eq("rst_addr",  128'(bus.RD_ADDR),   128'(32'hC000_0000));
        check_eq("rst_data",  bus.o_rd_data,       128'(0));
        check_eq("rst_ch",    128'(bus.o_rd_ch),   128'(0));
`ifdef RD_TIMEOUT_EN
        check_eq("rst_toerr", 128'(bus.o_timeout_err), 128'(0));
`endif
    endtask

    // Wait for the read strobe, then check grant toggle, owner and address
    task automatic wait_start(input logic [2:0] ch);
        int n = 0;
        @(negedge clk);
        while (bus.RD_START !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_seen", 128'(bus.RD_START), 128'(1));
        exp_free[ch] = ~exp_free[ch];
        check_eq("grant_free", 128'(bus.o_free),  128'(exp_free));
        check_eq("rd_ch",      128'(bus.o_rd_ch), 128'(ch));
        check_eq("rd_addr",    128'(bus.RD_ADDR), 128'(exp_addr));
        exp_addr = exp_addr + 32'd16;
    endtask

    task automatic do_read(input logic [2:0] ch, input logic [127:0] data);
        int n = 0;
        wait_start(ch);
        @(negedge clk);
        check_eq("start_1cyc", 128'(bus.RD_START), 128'(0));
        bus.RD_DONE = 1'b1;
        bus.RD_DATA = data;
        @(negedge clk);
        bus.RD_DONE = 1'b0;
        bus.RD_DATA = '0;
        exp_drive[ch] = ~exp_drive[ch];
        while (bus.o_drive !== exp_drive && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("drive_tog", 128'(bus.o_drive), 128'(exp_drive));
        check_eq("rd_data",   bus.o_rd_data,     data);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 128'(bus.o_busy), 128'(0));
    endtask

    initial begin
        int             n;
        int             viol;
        logic [127:0]   saved;

        rst = 1'b0;
        bus.i_drive = '0;  bus.i_free = '0;  bus.RD_DONE = 1'b0;  bus.RD_DATA = '0;
        bus_w.i_drive = '0; bus_w.i_free = '0; bus_w.RD_DONE = 1'b0; bus_w.RD_DATA = '0;
        exp_free = '0; exp_drive = '0; exp_addr = 32'hC000_0000;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;

        // Single read on channel 0
        req(3'd0);
        do_read(3'd0, 128'h1234);
        check_eq("busy_deliver", 128'(bus.o_busy), 128'(1));
        ack(3'd0);
        wait_idle("idle_after_ack");

        // Contention: 1,3,4 together, then 0 and 1 together
        @(negedge clk);
        bus.i_drive[1] = ~bus.i_drive[1];
        bus.i_drive[3] = ~bus.i_drive[3];
        bus.i_drive[4] = ~bus.i_drive[4];
        do_read(3'd1, 128'hA1); ack(3'd1);
        do_read(3'd3, 128'hA3); ack(3'd3);
        do_read(3'd4, 128'hA4); ack(3'd4);
        @(negedge clk);
        bus.i_drive[0] = ~bus.i_drive[0];
        bus.i_drive[1] = ~bus.i_drive[1];
        do_read(3'd0, 128'hB0); ack(3'd0);
        do_read(3'd1, 128'hB1); ack(3'd1);

        // Sequential pointer on channel 2
        for (int i = 0; i < 3; i++) begin
            req(3'd2);
            do_read(3'd2, {32'hDEAD_BEEF, 64'h0, 32'(i)});
            ack(3'd2);
        end

        // Hold: channel 3 delivered but not acknowledged, channel 0 waiting
        req(3'd3);
        do_read(3'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        req(3'd0);
        saved = bus.o_rd_data;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.RD_START !== 1'b0 || bus.o_rd_data !== saved || bus.o_free !== exp_free) viol++;
        end
        check_eq("hold_quiet", 128'(viol), 128'(0));
        check_eq("hold_busy",  128'(bus.o_busy), 128'(1));
        ack(3'd3);
        do_read(3'd0, 128'h5555);
        ack(3'd0);
        wait_idle("idle_after_hold");

        // Reset during WAIT abandons the read; a late RD_DONE is ignored
        req(3'd1);
        wait_start(3'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.i_drive = '0; bus.i_free = '0;
        exp_free = '0; exp_drive = '0; exp_addr = 32'hC000_0000;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.RD_DONE = 1'b1;
        bus.RD_DATA = 128'hBAD;
        @(negedge clk);
        bus.RD_DONE = 1'b0;
        bus.RD_DATA = '0;
        repeat (8) @(negedge clk);
        check_eq("late_done_drive", 128'(bus.o_drive),   128'(0));
        check_eq("late_done_data",  bus.o_rd_data,       128'(0));
        check_eq("late_done_busy",  128'(bus.o_busy),    128'(0));
        req(3'd2);
        do_read(3'd2, 128'h77);
        ack(3'd2);
        wait_idle("idle_after_rst");

`ifdef RD_TIMEOUT_EN
        // Watchdog: no RD_DONE, completion arrives with zero data
        req(3'd0);
        wait_start(3'd0);
        n = 0;
        exp_drive[0] = ~exp_drive[0];
        while (bus.o_drive !== exp_drive && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_drive",  128'(bus.o_drive), 128'(exp_drive));
        check_eq("to_lat",    128'(n >= 8 && n <= 10), 128'(1));
        check_eq("to_data",   bus.o_rd_data, 128'(0));
        check_eq("to_err",    128'(bus.o_timeout_err), 128'(1));
        ack(3'd0);
        req(3'd1);
        do_read(3'd1, 128'h99);
        check_eq("to_sticky", 128'(bus.o_timeout_err), 128'(1));
        ack(3'd1);
`endif

        // Pointer wrap on the second instance
        @(negedge clk);
        bus_w.i_drive[0] = 1'b1;
        n = 0;
        while (bus_w.RD_START !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("wrap_start0", 128'(bus_w.RD_START), 128'(1));
        check_eq("wrap_addr0",  128'(bus_w.RD_ADDR),  128'(32'hFFFF_FFF0));
        @(negedge clk);
        bus_w.RD_DONE = 1'b1;
        bus_w.RD_DATA = 128'hF0;
        @(negedge clk);
        bus_w.RD_DONE = 1'b0;
        n = 0;
        while (bus_w.o_drive[0] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("wrap_drive",  128'(bus_w.o_drive), 128'(1));
        bus_w.i_free[0]  = 1'b1;
        bus_w.i_drive[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus_w.RD_START !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("wrap_start1", 128'(bus_w.RD_START), 128'(1));
        check_eq("wrap_addr1",  128'(bus_w.RD_ADDR),  128'(32'h0000_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
